// File: rtl/instr_type_pkg.sv
// Shared instruction-side types: decoded store kinds and store-unit error causes.
package instr_type;

  // Store kind as produced by the store decoder.
  typedef enum logic [1:0] {
    sk_sb      = 2'd0,
    sk_sh      = 2'd1,
    sk_sw      = 2'd2,
    sk_invalid = 2'd3
  } store_kind_t;

  // Reason attached to an err pulse from the store unit.
  typedef enum logic [1:0] {
    se_none       = 2'd0,
    se_misaligned = 2'd1,
    se_invalid    = 2'd2,
    se_timeout    = 2'd3
  } store_err_t;

  // Width of a wait counter able to hold 0..limit, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/store_unit_lane_align.sv
// Maps a store kind and the low address bits onto byte-lane enables and
// lane-replicated write data, and flags illegal or misaligned requests.
module store_lane_align
  import instr_type::*;
(
  input  store_kind_t kind,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        invalid
);

  // Lane select and alignment check per store kind.
  always_comb begin
    be         = 4'b0000;
    data       = 32'h0000_0000;
    misaligned = 1'b0;
    invalid    = 1'b0;
    case (kind)
      sk_sb: begin
        be   = 4'b0001 << addr;
        data = {4{wdata[7:0]}};
      end
      sk_sh: begin
        be         = addr[1] ? 4'b1100 : 4'b0011;
        data       = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      sk_sw: begin
        be         = 4'b1111;
        data       = wdata;
        misaligned = |addr;
      end
      default: begin
        invalid = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one decoded store per handshake, drives a word-aligned
// write with byte enables onto the data-memory port and reports completion
// or failure as single-cycle pulses.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | ready for a new store; illegal requests are rejected here
//   ST_REQ   | mem_req held with stable address/data/enables, awaiting ack
module store_unit
  import instr_type::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  store_kind_t       kind,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output store_err_t        err_cause
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT);
  localparam logic [CNT_W:0] CNT_ONE  = (CNT_W + 1)'(1);

  logic [0:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W:0]   cnt_inc;
  logic             timeout_hit;
  logic             accept;

  logic [3:0]       al_be;
  logic [31:0]      al_data;
  logic             al_misaligned;
  logic             al_invalid;

  store_lane_align u_align (
    .kind       (kind),
    .addr       (addr[1:0]),
    .wdata      (wdata),
    .be         (al_be),
    .data       (al_data),
    .misaligned (al_misaligned),
    .invalid    (al_invalid)
  );

  // Ready only in IDLE and never while reset is held, so nothing is accepted
  // on the edge that releases reset.
  always_comb begin
    in_ready = (state == ST_IDLE) && rst;
    accept   = in_valid && in_ready;
  end

  // Wait-count compare: the count is widened by one bit so the increment
  // can be compared against TIMEOUT without wrapping; TIMEOUT=0 never fires.
  always_comb begin
    cnt_inc     = {1'b0, wait_cnt} + CNT_ONE;
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_LIMIT);
  end

  // Control FSM, wait counter and the done/err pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= se_none;
      wait_cnt  <= '0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      err_cause <= se_none;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (al_invalid) begin
              err       <= 1'b1;
              err_cause <= se_invalid;
            end else if (al_misaligned) begin
              err       <= 1'b1;
              err_cause <= se_misaligned;
            end else begin
              mem_req  <= 1'b1;
              wait_cnt <= '0;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            done     <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else if (timeout_hit) begin
            mem_req   <= 1'b0;
            err       <= 1'b1;
            err_cause <= se_timeout;
            wait_cnt  <= '0;
            state     <= ST_IDLE;
          end else begin
            wait_cnt <= cnt_inc[CNT_W-1:0];
          end
        end
        default: begin
          mem_req  <= 1'b0;
          wait_cnt <= '0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-port payload: captured only on a legal accept and held through REQ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (accept && !al_invalid && !al_misaligned) begin
      mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
      mem_wdata <= al_data;
      mem_be    <= al_be;
    end
  end

endmodule

// File: doc/store_unit.md
# store_unit

Executes one decoded RV32I store per handshake: it takes the store kind, effective address and rs2 value, and drives a word-aligned write with byte enables onto the data-memory port. It sits between the execute stage and the data-memory interface. It handles the sb/sh/sw kinds produced by the store decoder. Illegal kinds, misalignment and memory timeout are reported as one-cycle error pulses with a cause code.

## Interface
Parameters:
- ADDR_W, 32, address width in bits
- TIMEOUT, 255, maximum cycles to wait for mem_ack while mem_req is high; 0 disables the timeout

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  store request from execute
- in_ready  out  1  unit can accept; equals (state==IDLE) && rst
- kind  in  store_kind_t  sk_sb / sk_sh / sk_sw / sk_invalid
- addr  in  ADDR_W  effective byte address
- wdata  in  32  rs2 value
- mem_req  out  1  write request, held until acknowledged or timed out
- mem_addr  out  ADDR_W  addr with bits [1:0] forced to 0
- mem_wdata  out  32  lane-replicated write data
- mem_be  out  4  byte enables, bit i = byte lane i
- mem_ack  in  1  memory accepted the write; ignored while mem_req is 0
- done  out  1  one-cycle pulse: store completed
- err  out  1  one-cycle pulse: store rejected or failed
- err_cause  out  store_err_t  valid when err=1, otherwise se_none

## Operation
- FSM states: IDLE, REQ.
- IDLE: when in_valid && in_ready at an edge, the request is checked.
  - If kind is sk_invalid, or the kind is not sb/sh/sw: err with se_invalid.
  - sh with addr[0]=1, or sw with addr[1:0]≠0: err with se_misaligned.
  - On either error, no memory access occurs and the state stays IDLE.
  - Otherwise mem_addr, mem_wdata and mem_be are registered, mem_req is set, and the state goes to REQ.
- Lane rules, with a = addr[1:0]:
  - sb: be = 4'b0001 << a; data = {4{wdata[7:0]}}
  - sh: be = a[1] ? 4'b1100 : 4'b0011; data = {2{wdata[15:0]}}
  - sw: be = 4'b1111; data = wdata
- REQ:
  - mem_addr, mem_wdata, mem_be and mem_req are held stable.
  - The wait counter increments each cycle.
  - mem_ack=1 at an edge: mem_req←0, done←1, state←IDLE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no ack: mem_req←0, err←1, err_cause←se_timeout, state←IDLE.
  - If ack and timeout occur at the same edge, ack wins.
- in_valid is ignored outside IDLE. The upstream stage must hold its fields while in_valid && !in_ready.

## Timing
- Reset values (async, while rst=0): state IDLE; mem_req, done, err = 0; mem_addr, mem_wdata, mem_be = 0; err_cause = se_none; counter = 0; in_ready = 0.
- Accept at edge T:
  - mem_req = 1 from T+1.
  - If ack is seen at edge T+k (k≥1), done = 1 in cycle T+k+1 only, and in_ready = 1 again in that same cycle. Back-to-back throughput is one store per 2 cycles with a zero-wait memory.
- Error at accept edge T: err = 1 and err_cause valid in cycle T+1 only. in_ready stays 1, so a new request may be accepted at edge T+1.
- Timeout: err pulse in the cycle after the edge where the counter hits TIMEOUT, i.e. the TIMEOUT+1-th cycle after mem_req rose.
- done and err are never high together.
- Reset asserted mid-REQ: mem_req drops immediately (async) and no done or err is produced.

## Structure
- Package instr_type (existing): keep store_kind_t; add the enum store_err_t {se_none=2'd0, se_misaligned=2'd1, se_invalid=2'd2, se_timeout=2'd3}.
- Sub-module store_lane_align (combinational): inputs kind, addr[1:0], wdata; outputs be[3:0], data[31:0], misaligned, invalid. It is instantiated once in store_unit.
- Wait-counter width: $clog2(TIMEOUT+1), minimum 1.

## Test plan
- sb, addr=0x1003, wdata=0xAABBCCDD, ack after 2 cycles -> mem_addr=0x1000, mem_be=4'b1000, mem_wdata=0xDDDDDDDD; mem_req high 2 cycles; done pulse 1 cycle; in_ready=1 with done.
- sh at 0x2002, wdata=0x12345678, ack held 1 every cycle, 3 back-to-back requests -> be=4'b1100, data=0x56785678, done every 2nd cycle.
- sw at 0x3001 -> no mem_req; err=1 with se_misaligned in the next cycle; the following sw at 0x3004 is accepted at that edge.
- kind=sk_invalid -> err=1 with se_invalid; mem_req stays 0.
- TIMEOUT=4, ack never asserted -> mem_req high 4 cycles, then err with se_timeout; with ack arriving on the 4th edge instead, done=1 and no err.
- rst pulled low during REQ -> mem_req=0 and in_ready=0 immediately; after release in_ready=1 and no done or err pulse.
